// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks in-flight producers from EX onward and
// chooses a forward tap per source operand of the ID instruction, or stalls it.
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NSRC     = 3,
    parameter int DEPTH    = 3,
    parameter int ZERO_REG = 1,
    parameter int CNTW     = 16,
    parameter int LATW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*REG_AW-1:0] id_src,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_regwrite,
    input  logic [LATW-1:0]        id_res_stage,
    input  logic                   flush,
    output logic                   stall,
    output logic [NSRC*LATW-1:0]   fwd_sel,
    output logic                   ex_valid,
    output logic [CNTW-1:0]        stall_cnt
);

    // Shadow of producers; index 1 is EX, index DEPTH is the oldest tracked stage.
    logic              sh_v  [1:DEPTH];
    logic [REG_AW-1:0] sh_rd [1:DEPTH];
    logic              sh_rw [1:DEPTH];
    logic [LATW-1:0]   sh_rs [1:DEPTH];

    logic [LATW-1:0]      rs_norm;
    logic [NSRC*LATW-1:0] sel_next;
    logic                 hazard;
    logic                 accept;
    logic                 hit;
    logic                 hit_ok;
    logic [LATW-1:0]      hit_k;

    assign rs_norm = (id_res_stage == '0) ? LATW'(1) : id_res_stage;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hazard   = 1'b0;
        sel_next = '0;
        hit      = 1'b0;
        hit_ok   = 1'b0;
        hit_k    = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit    = 1'b0;
            hit_ok = 1'b0;
            hit_k  = '0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (sh_v[k] && sh_rw[k] && id_src_used[i] &&
                    (sh_rd[k] == id_src[i*REG_AW +: REG_AW]) &&
                    !((ZERO_REG != 0) && (sh_rd[k] == '0))) begin
                    hit    = 1'b1;
                    hit_k  = LATW'(k);
                    hit_ok = (LATW'(k) >= sh_rs[k]);
                end
            end
            if (hit) begin
                if (hit_ok)
                    sel_next[i*LATW +: LATW] = hit_k;
                else
                    hazard = 1'b1;
            end
        end
    end

    assign stall  = id_valid && !flush && hazard;
    assign accept = id_valid && !flush && !hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) begin
                sh_v[k]  <= 1'b0;
                sh_rd[k] <= '0;
                sh_rw[k] <= 1'b0;
                sh_rs[k] <= '0;
            end
            fwd_sel   <= '0;
            ex_valid  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                sh_v[k]  <= sh_v[k-1];
                sh_rd[k] <= sh_rd[k-1];
                sh_rw[k] <= sh_rw[k-1];
                sh_rs[k] <= sh_rs[k-1];
            end
            sh_v[1]  <= accept;
            sh_rd[1] <= accept ? id_rd : '0;
            sh_rw[1] <= accept && id_regwrite;
            sh_rs[1] <= accept ? rs_norm : '0;
            fwd_sel  <= accept ? sel_next : '0;
            ex_valid <= accept;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule
